// File: rtl/membus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : membus_pkg
//  Description : Shared types and constants for the memory bus controller:
//                FSM state encoding, mdr_sel encodings, wait-counter width.
//  Revision    : 1.0  initial release
// ============================================================================
package membus_pkg;

    localparam int WAIT_CNT_W = 4;

    localparam logic [1:0] MDRS_MEM = 2'd0;
    localparam logic [1:0] MDRS_BUS = 2'd1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/strobe_rise.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_rise
//  Description : Rising-edge detector for a decoder level strobe. Remembers
//                the previous-cycle sample and flags a 0->1 transition.
//  Revision    : 1.0  initial release
// ============================================================================
module strobe_rise (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic rise
);

    logic r_prev;

    // Previous-cycle sample of the strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= strobe;
        end
    end

    assign rise = strobe & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bus_ctrl
//  Description : Owns MAR/IR/MDR and converts decoder load strobes into single
//                SRAM read/write transactions with wait states and an SRAM
//                ready handshake.
//                Optional macro MEMCTRL_BYTE_ACCESS_EN enables byte accesses
//                on MDR reads and on writes.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_bus_ctrl
    import membus_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mar_load,
    input  logic        ir_load,
    input  logic        mdr_load,
    input  logic        ram_load,
    input  logic        be,
    input  logic [1:0]  mdr_sel,
    input  logic [15:0] mar_din,
    input  logic [15:0] mdr_din,
    output logic [15:0] instr,
    output logic [15:0] mdr_q,
    output logic [15:0] mar_q,
    output logic        busy,
    output logic        err,
    output logic [14:0] sram_addr,
    output logic [15:0] sram_wdata,
    input  logic [15:0] sram_rdata,
    output logic        sram_ce,
    output logic        sram_oe,
    output logic        sram_we,
    output logic [1:0]  sram_bwe,
    input  logic        sram_rdy
);

    localparam logic [WAIT_CNT_W-1:0] c_wait_init = WAIT_CNT_W'(WAIT_STATES);
    localparam logic [WAIT_CNT_W-1:0] c_wait_one  = WAIT_CNT_W'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait;
    logic [15:0]           r_mar;
    logic [15:0]           r_ir;
    logic [15:0]           r_mdr;
    logic [15:0]           r_xaddr;   // MAR as it stood when the transaction opened
    logic                  r_wr;
    logic                  r_tgt_ir;
    logic                  r_err;

    logic        w_ir_rise;
    logic        w_mdr_rise;
    logic        w_ram_rise;
    logic        w_mdr_mem_rise;
    logic        w_mdr_direct;
    logic        w_accept;
    logic        w_acc_wr;
    logic        w_acc_ir;
    logic        w_complete;
    logic        w_conflict;
    logic [15:0] w_rd_data;
    logic [1:0]  w_bwe_wr;
    logic [15:0] w_wdata;

    strobe_rise u_ir_rise  (.clk(clk), .reset(reset), .strobe(ir_load),  .rise(w_ir_rise));
    strobe_rise u_mdr_rise (.clk(clk), .reset(reset), .strobe(mdr_load), .rise(w_mdr_rise));
    strobe_rise u_ram_rise (.clk(clk), .reset(reset), .strobe(ram_load), .rise(w_ram_rise));

    assign w_mdr_mem_rise = w_mdr_rise & (mdr_sel == MDRS_MEM);
    assign w_mdr_direct   = (r_state == IDLE) & w_mdr_rise & (mdr_sel != MDRS_MEM);

    // Next-state, accept arbitration (write > IR read > MDR read) and conflicts
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_acc_wr    = 1'b0;
        w_acc_ir    = 1'b0;
        w_complete  = 1'b0;
        w_conflict  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ram_rise) begin
                    w_accept   = 1'b1;
                    w_acc_wr   = 1'b1;
                    w_conflict = w_ir_rise | w_mdr_mem_rise;
                end else if (w_ir_rise) begin
                    w_accept   = 1'b1;
                    w_acc_ir   = 1'b1;
                    w_conflict = w_mdr_mem_rise;
                end else if (w_mdr_mem_rise) begin
                    w_accept   = 1'b1;
                end
                if (w_accept) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_conflict = w_ir_rise | w_mdr_rise | w_ram_rise;
                if ((r_wait == '0) && sram_rdy) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef MEMCTRL_BYTE_ACCESS_EN
    logic r_be;

    // Byte-access flag is frozen for the life of the transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_be <= 1'b0;
        end else if (w_accept) begin
            r_be <= be;
        end
    end

    // IR fetches stay full-word; MDR byte reads zero-extend the addressed lane
    assign w_rd_data = (r_be && !r_tgt_ir)
                     ? {8'h00, (r_xaddr[0] ? sram_rdata[15:8] : sram_rdata[7:0])}
                     : sram_rdata;
    assign w_bwe_wr  = r_be ? (r_xaddr[0] ? 2'b10 : 2'b01) : 2'b11;
    assign w_wdata   = r_be ? {r_mdr[7:0], r_mdr[7:0]} : r_mdr;
`else
    logic w_unused;

    assign w_unused  = be ^ r_xaddr[0];
    assign w_rd_data = sram_rdata;
    assign w_bwe_wr  = 2'b11;
    assign w_wdata   = r_mdr;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Wait-state counter: loaded on accept, counts down to zero in ACCESS
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= '0;
        end else if (w_accept) begin
            r_wait <= c_wait_init;
        end else if ((r_state == ACCESS) && (r_wait != '0)) begin
            r_wait <= r_wait - c_wait_one;
        end
    end

    // Transaction attributes captured from pre-edge MAR at accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_xaddr  <= '0;
            r_wr     <= 1'b0;
            r_tgt_ir <= 1'b0;
        end else if (w_accept) begin
            r_xaddr  <= r_mar;
            r_wr     <= w_acc_wr;
            r_tgt_ir <= w_acc_ir;
        end
    end

    // MAR follows mar_din while idle; frozen while a transaction is open
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mar <= '0;
        end else if ((r_state == IDLE) && mar_load) begin
            r_mar <= mar_din;
        end
    end

    // IR/MDR: read completion capture, or direct MDR load from the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ir  <= '0;
            r_mdr <= '0;
        end else if (w_complete && !r_wr) begin
            if (r_tgt_ir) begin
                r_ir  <= w_rd_data;
            end else begin
                r_mdr <= w_rd_data;
            end
        end else if (w_mdr_direct) begin
            r_mdr <= mdr_din;
        end
    end

    // One-cycle error pulse after a conflicting edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_conflict;
        end
    end

    assign instr      = r_ir;
    assign mdr_q      = r_mdr;
    assign mar_q      = r_mar;
    assign busy       = (r_state == ACCESS);
    assign err        = r_err;
    assign sram_ce    = busy;
    assign sram_oe    = busy & ~r_wr;
    assign sram_we    = busy & r_wr;
    assign sram_bwe   = sram_we ? w_bwe_wr : 2'b00;
    assign sram_addr  = busy ? r_xaddr[15:1] : r_mar[15:1];
    assign sram_wdata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_ctrl
//  Description : Self-checking bench for mem_bus_ctrl: directed scenarios
//                followed by randomized strobes, compared every cycle against
//                a transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int unsigned TB_WS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mar_load, ir_load, mdr_load, ram_load, be;
    logic [1:0]  mdr_sel;
    logic [15:0] mar_din, mdr_din, sram_rdata;
    logic        sram_rdy;
    logic [15:0] instr, mdr_q, mar_q, sram_wdata;
    logic        busy, err, sram_ce, sram_oe, sram_we;
    logic [14:0] sram_addr;
    logic [1:0]  sram_bwe;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_mar, m_ir, m_mdr, m_addr;
    bit          m_busy, m_wr, m_to_ir, m_be, m_err;
    bit          m_p_ir, m_p_mdr, m_p_ram;
    int          m_age;

    mem_bus_ctrl #(.WAIT_STATES(TB_WS)) dut (
        .clk(clk), .reset(reset), .mar_load(mar_load), .ir_load(ir_load),
        .mdr_load(mdr_load), .ram_load(ram_load), .be(be), .mdr_sel(mdr_sel),
        .mar_din(mar_din), .mdr_din(mdr_din), .instr(instr), .mdr_q(mdr_q),
        .mar_q(mar_q), .busy(busy), .err(err), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_ce(sram_ce),
        .sram_oe(sram_oe), .sram_we(sram_we), .sram_bwe(sram_bwe),
        .sram_rdy(sram_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit byte_mode();
`ifdef MEMCTRL_BYTE_ACCESS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_clear();
        m_mar = '0; m_ir = '0; m_mdr = '0; m_addr = '0;
        m_busy = 0; m_wr = 0; m_to_ir = 0; m_be = 0; m_err = 0;
        m_p_ir = 0; m_p_mdr = 0; m_p_ram = 0; m_age = 0;
    endtask

    // One clock edge of behaviour, from the pre-edge inputs
    task automatic model_edge();
        bit ri, rm, rw, rd_mdr;
        ri = ir_load  && !m_p_ir;
        rm = mdr_load && !m_p_mdr;
        rw = ram_load && !m_p_ram;
        m_err = 0;
        if (m_busy) begin
            if (ri || rm || rw) m_err = 1;
            m_age++;
            if (m_age > int'(TB_WS) && sram_rdy) begin
                m_busy = 0;
                if (!m_wr) begin
                    if (m_to_ir)
                        m_ir = sram_rdata;
                    else if (byte_mode() && m_be)
                        m_mdr = m_addr[0] ? {8'h00, sram_rdata[15:8]} : {8'h00, sram_rdata[7:0]};
                    else
                        m_mdr = sram_rdata;
                end
            end
        end else begin
            rd_mdr = rm && (mdr_sel == 2'd0);
            if (rm && mdr_sel != 2'd0) m_mdr = mdr_din;
            if (rw || ri || rd_mdr) begin
                m_busy  = 1;
                m_age   = 0;
                m_addr  = m_mar;
                m_be    = be;
                m_wr    = rw;
                m_to_ir = !rw && ri;
                m_err   = (rw && (ri || rd_mdr)) || (!rw && ri && rd_mdr);
            end
            if (mar_load) m_mar = mar_din;
        end
        m_p_ir = ir_load; m_p_mdr = mdr_load; m_p_ram = ram_load;
    endtask

    task automatic check_all();
        logic [15:0] e_addr;
        e_addr = m_busy ? m_addr : m_mar;
        chk("instr",   instr, m_ir);
        chk("mdr_q",   mdr_q, m_mdr);
        chk("mar_q",   mar_q, m_mar);
        chk("busy",    busy, m_busy);
        chk("err",     err, m_err);
        chk("sram_ce", sram_ce, m_busy);
        chk("sram_oe", sram_oe, m_busy && !m_wr);
        chk("sram_we", sram_we, m_busy && m_wr);
        chk("sram_addr", sram_addr, e_addr[15:1]);
        if (m_busy && m_wr) begin
            if (byte_mode() && m_be) begin
                chk("sram_bwe",   sram_bwe, m_addr[0] ? 16'd2 : 16'd1);
                chk("sram_wdata", sram_wdata, {m_mdr[7:0], m_mdr[7:0]});
            end else begin
                chk("sram_bwe",   sram_bwe, 16'd3);
                chk("sram_wdata", sram_wdata, m_mdr);
            end
        end else begin
            chk("sram_bwe", sram_bwe, 16'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_clear();
        else       model_edge();
        #1;
        check_all();
    endtask

    task automatic strobes_off();
        mar_load = 0; ir_load = 0; mdr_load = 0; ram_load = 0;
    endtask

    // Tick until idle; n counts busy samples seen, bounded
    task automatic wait_idle(output int n);
        int k;
        n = 0;
        k = 0;
        while (busy && k < 60) begin
            n++;
            k++;
            tick();
        end
        chk("timeout_busy", busy, 1'b0);
    endtask

    initial begin
        int nb;
        logic [15:0] rd;

        reset = 1; strobes_off(); be = 0; mdr_sel = 0;
        mar_din = 0; mdr_din = 0; sram_rdata = 0; sram_rdy = 1;
        model_clear();
        tick();
        tick();
        chk("rst_instr", instr, 16'h0000);
        chk("rst_bwe",   sram_bwe, 16'h0000);
        reset = 0;
        tick();

        // MAR = 0x0010, IR fetch strobe held for two cycles
        mar_load = 1; mar_din = 16'h0010;
        tick();
        mar_load = 0; ir_load = 1; sram_rdata = 16'hA5C3; sram_rdy = 1;
        tick();
        chk("t2_addr", sram_addr, 15'h0008);
        chk("t2_oe",   sram_oe, 1'b1);
        tick();
        ir_load = 0;
        wait_idle(nb);
        chk("t2_busy_cycles", nb + 1, TB_WS + 1);
        chk("t2_instr", instr, 16'hA5C3);
        tick();
        chk("t2_single_access", busy, 1'b0);

        // MDR memory read with three extra ready-stall cycles
        sram_rdy = 0; mdr_sel = 0; mdr_load = 1; sram_rdata = 16'h5A17;
        tick();
        mdr_load = 0;
        nb = busy;
        for (int k = 0; k < int'(TB_WS) + 3; k++) begin
            tick();
            nb += busy;
        end
        sram_rdy = 1;
        tick();
        nb += busy;
        chk("t3_busy_cycles", nb, TB_WS + 4);
        chk("t3_mdr", mdr_q, 16'h5A17);

        // Direct MDR load, then write it out
        mdr_sel = 1; mdr_load = 1; mdr_din = 16'h1234;
        tick();
        chk("t4_mdr_direct", mdr_q, 16'h1234);
        chk("t4_no_busy", busy, 1'b0);
        mdr_load = 0;
        tick();
        ram_load = 1;
        tick();
        chk("t4_we", sram_we, 1'b1);
        chk("t4_wdata", sram_wdata, 16'h1234);
        chk("t4_bwe", sram_bwe, 16'd3);
        ram_load = 0;
        nb = sram_we;
        while (busy && nb < 60) begin
            tick();
            nb += sram_we;
        end
        chk("t4_we_cycles", nb, TB_WS + 1);

        // Write and IR read rise together: write wins, err pulses once
        ram_load = 1; ir_load = 1; sram_rdata = 16'hDEAD;
        tick();
        chk("t5_err", err, 1'b1);
        chk("t5_we", sram_we, 1'b1);
        strobes_off();
        tick();
        chk("t5_err_clear", err, 1'b0);
        wait_idle(nb);
        chk("t5_instr_kept", instr, 16'hA5C3);
        tick();

`ifdef MEMCTRL_BYTE_ACCESS_EN
        // Byte read from the odd lane, then byte write to the odd lane
        mar_load = 1; mar_din = 16'h0021;
        tick();
        mar_load = 0; be = 1; mdr_sel = 0; mdr_load = 1; sram_rdata = 16'hBEEF;
        tick();
        mdr_load = 0;
        wait_idle(nb);
        chk("t6_byte_rd", mdr_q, 16'h00BE);
        mdr_sel = 1; mdr_load = 1; mdr_din = 16'h0077;
        tick();
        mdr_load = 0;
        tick();
        ram_load = 1;
        tick();
        chk("t6_bwe", sram_bwe, 16'd2);
        chk("t6_wdata", sram_wdata, 16'h7777);
        ram_load = 0;
        wait_idle(nb);
        be = 0;
        tick();
`endif

        // Reset while a read is stalled in ACCESS
        sram_rdy = 0; ir_load = 1; sram_rdata = 16'hFFFF;
        tick();
        tick();
        chk("t7_busy_before", busy, 1'b1);
        strobes_off();
        reset = 1;
        #1;
        model_clear();
        chk("t7_ce_async", sram_ce, 1'b0);
        chk("t7_oe_async", sram_oe, 1'b0);
        chk("t7_busy_async", busy, 1'b0);
        tick();
        chk("t7_instr", instr, 16'h0000);
        reset = 0;
        sram_rdy = 1;
        tick();

        // Randomized strobes against the reference model
        for (int i = 0; i < 600; i++) begin
            mar_load   = ($urandom_range(3) == 0);
            if ($urandom_range(4) == 0) ir_load  = ~ir_load;
            if ($urandom_range(4) == 0) mdr_load = ~mdr_load;
            if ($urandom_range(5) == 0) ram_load = ~ram_load;
            mdr_sel    = 2'($urandom_range(3));
            be         = 1'($urandom_range(1));
            mar_din    = 16'($urandom);
            mdr_din    = 16'($urandom);
            rd         = 16'($urandom);
            sram_rdata = rd;
            sram_rdy   = ($urandom_range(2) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
